// File: rtl/ray_tracer_pkg.sv
// Shared definitions for the closest-hit scan controller: object word and
// ray packing field positions, common widths, the "no hit" t value and the
// scan FSM state encoding.
package ray_tracer_pkg;

  localparam int T_W     = 10;
  localparam int COLOR_W = 12;
  localparam int RAY_W   = 28;
  localparam int OBJ_W   = 50;

  // Object word: {color[11:0], radius[9:0], center[27:0]}
  localparam int COLOR_MSB  = 49;
  localparam int COLOR_LSB  = 38;
  localparam int RADIUS_MSB = 37;
  localparam int RADIUS_LSB = 28;
  localparam int CENTER_MSB = 27;
  localparam int CENTER_LSB = 0;

  // Ray / position packing: {x[9:0], y[9:0], z[7:0]}
  localparam int X_MSB = 27;
  localparam int X_LSB = 18;
  localparam int Y_MSB = 17;
  localparam int Y_LSB = 8;
  localparam int Z_MSB = 7;
  localparam int Z_LSB = 0;

  localparam logic [T_W-1:0] T_MISS = 10'h3FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_TEST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A returned t is usable only if it is a real intersection and not a
  // self-intersection at the ray origin (t == 0).
  function automatic logic t_is_candidate(input logic [T_W-1:0] t,
                                          input logic [T_W-1:0] miss);
    t_is_candidate = (t != miss) && (t != {T_W{1'b0}});
  endfunction

endpackage

// File: rtl/ray_tracer_min_t.sv
// Combinational accept/compare cell: decides whether a candidate t beats
// the current best and produces the next best state. Strict less-than so
// that on equal t the earlier (lower-index) object is kept.
module ray_tracer_min_t
  import ray_tracer_pkg::*;
#(
  parameter int               ADDR_W = 3,
  parameter logic [T_W-1:0]   MISS_T = T_MISS
) (
  input  logic [T_W-1:0]     cand_t,
  input  logic [ADDR_W-1:0]  cand_index,
  input  logic [COLOR_W-1:0] cand_color,
  input  logic               best_valid,
  input  logic [T_W-1:0]     best_t,
  input  logic [COLOR_W-1:0] best_color,
  input  logic [ADDR_W-1:0]  best_index,
  output logic               accept,
  output logic               next_valid,
  output logic [T_W-1:0]     next_t,
  output logic [COLOR_W-1:0] next_color,
  output logic [ADDR_W-1:0]  next_index
);

  // Accept the candidate if it is a usable hit nearer than the best so far.
  always_comb begin
    accept     = 1'b0;
    next_valid = best_valid;
    next_t     = best_t;
    next_color = best_color;
    next_index = best_index;
    if (t_is_candidate(cand_t, MISS_T) && (!best_valid || (cand_t < best_t))) begin
      accept     = 1'b1;
      next_valid = 1'b1;
      next_t     = cand_t;
      next_color = cand_color;
      next_index = cand_index;
    end else begin
      accept     = 1'b0;
    end
  end

endmodule

// File: rtl/ray_tracer_closest_hit.sv
// Closest-hit scan controller. Latches one ray, walks the object table
// through a synchronous ROM, presents each object with the ray to the
// intersection stage, keeps the nearest valid hit and hands it downstream
// over a valid/ready handshake.
// Optional feature macro: RT_ANY_HIT_EN (adds any_hit input; a latched
// any_hit ends the scan at the first accepted hit, for shadow rays).
module ray_tracer_closest_hit
  import ray_tracer_pkg::*;
#(
  parameter int                 NUM_OBJ  = 8,
  parameter int                 ADDR_W   = 3,
  parameter logic [T_W-1:0]     T_MISS   = ray_tracer_pkg::T_MISS,
  parameter logic [COLOR_W-1:0] BG_COLOR = 12'h000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
`ifdef RT_ANY_HIT_EN
  input  logic               any_hit,
`endif
  output logic               in_ready,
  input  logic [RAY_W-1:0]   ray_init,
  input  logic [RAY_W-1:0]   ray_dir,
  output logic [ADDR_W-1:0]  obj_addr,
  input  logic [OBJ_W-1:0]   obj_data,
  output logic [RAY_W-1:0]   isect_init,
  output logic [RAY_W-1:0]   isect_dir,
  output logic [OBJ_W-1:0]   isect_obj,
  input  logic [T_W-1:0]     isect_t,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COLOR_W-1:0] hit_color,
  output logic [T_W-1:0]     hit_t,
  output logic               hit_valid,
  output logic [ADDR_W-1:0]  hit_index
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OBJ - 1);

  state_t              state_r;
  state_t              state_s;

  // isect_obj holds a real object to compare (false on the first TEST cycle)
  logic                cmp_en_r;
  // index of the object currently sitting in isect_obj
  logic [ADDR_W-1:0]   cmp_idx_r;

  logic                best_valid_r;
  logic [T_W-1:0]      best_t_r;
  logic [COLOR_W-1:0]  best_color_r;
  logic [ADDR_W-1:0]   best_index_r;

  logic                accept_s;
  logic                next_valid_s;
  logic [T_W-1:0]      next_t_s;
  logic [COLOR_W-1:0]  next_color_s;
  logic [ADDR_W-1:0]   next_index_s;

  logic                take_ray_s;
  logic                scan_end_s;
  logic                shadow_mode_s;

  assign take_ray_s = (state_r == ST_IDLE) && in_valid;
  assign in_ready   = (state_r == ST_IDLE);
  assign out_valid  = (state_r == ST_DONE);

`ifdef RT_ANY_HIT_EN
  logic shadow_r;

  // Capture the shadow-ray request together with the ray itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_r <= 1'b0;
    end else if (take_ray_s) begin
      shadow_r <= any_hit;
    end
  end

  assign shadow_mode_s = shadow_r;
`else
  assign shadow_mode_s = 1'b0;
`endif

  ray_tracer_min_t #(
    .ADDR_W (ADDR_W),
    .MISS_T (T_MISS)
  ) u_min_t (
    .cand_t     (isect_t),
    .cand_index (cmp_idx_r),
    .cand_color (isect_obj[COLOR_MSB:COLOR_LSB]),
    .best_valid (best_valid_r),
    .best_t     (best_t_r),
    .best_color (best_color_r),
    .best_index (best_index_r),
    .accept     (accept_s),
    .next_valid (next_valid_s),
    .next_t     (next_t_s),
    .next_color (next_color_s),
    .next_index (next_index_s)
  );

  // The scan ends on the compare of the last object, or early on the first
  // accepted hit of a shadow ray.
  always_comb begin
    scan_end_s = 1'b0;
    if ((state_r == ST_TEST) && cmp_en_r) begin
      if (cmp_idx_r == LAST_IDX) begin
        scan_end_s = 1'b1;
      end else if (shadow_mode_s && accept_s) begin
        scan_end_s = 1'b1;
      end else begin
        scan_end_s = 1'b0;
      end
    end else begin
      scan_end_s = 1'b0;
    end
  end

  // Next-state logic for the IDLE -> FETCH -> TEST -> DONE scan.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_TEST;
      end
      ST_TEST: begin
        if (scan_end_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_TEST;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latch the accepted ray for the whole scan.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isect_init <= {RAY_W{1'b0}};
      isect_dir  <= {RAY_W{1'b0}};
    end else if (take_ray_s) begin
      isect_init <= ray_init;
      isect_dir  <= ray_dir;
    end
  end

  // ROM address: restart at 0 per ray, step once per cycle, park on the last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      obj_addr <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            obj_addr <= {ADDR_W{1'b0}};
          end
        end
        ST_FETCH, ST_TEST: begin
          if (obj_addr == LAST_IDX) begin
            obj_addr <= LAST_IDX;
          end else begin
            obj_addr <= obj_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          obj_addr <= obj_addr;
        end
      endcase
    end
  end

  // Object pipeline: register ROM data for the intersection stage and track
  // which object index its returned t belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isect_obj <= {OBJ_W{1'b0}};
      cmp_en_r  <= 1'b0;
      cmp_idx_r <= {ADDR_W{1'b0}};
    end else if (take_ray_s) begin
      cmp_en_r  <= 1'b0;
      cmp_idx_r <= {ADDR_W{1'b0}};
    end else if (state_r == ST_TEST) begin
      isect_obj <= obj_data;
      cmp_en_r  <= 1'b1;
      if (cmp_en_r) begin
        cmp_idx_r <= cmp_idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Best-hit registers: cleared per ray, updated on every compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_valid_r <= 1'b0;
      best_t_r     <= T_MISS;
      best_color_r <= BG_COLOR;
      best_index_r <= {ADDR_W{1'b0}};
    end else if (take_ray_s) begin
      best_valid_r <= 1'b0;
      best_t_r     <= T_MISS;
      best_color_r <= BG_COLOR;
      best_index_r <= {ADDR_W{1'b0}};
    end else if ((state_r == ST_TEST) && cmp_en_r) begin
      best_valid_r <= next_valid_s;
      best_t_r     <= next_t_s;
      best_color_r <= next_color_s;
      best_index_r <= next_index_s;
    end
  end

  // Result registers: loaded with the final best state as the scan ends and
  // held unchanged through DONE regardless of backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_valid <= 1'b0;
      hit_t     <= T_MISS;
      hit_color <= BG_COLOR;
      hit_index <= {ADDR_W{1'b0}};
    end else if (take_ray_s) begin
      hit_valid <= 1'b0;
      hit_t     <= T_MISS;
      hit_color <= BG_COLOR;
      hit_index <= {ADDR_W{1'b0}};
    end else if (scan_end_s) begin
      hit_valid <= next_valid_s;
      hit_t     <= next_t_s;
      hit_color <= next_color_s;
      hit_index <= next_index_s;
    end
  end

endmodule

// File: tb/tb_ray_tracer_closest_hit.sv
// Scoreboard bench for ray_tracer_closest_hit: a synchronous ROM and a
// t-table intersection model stand in for the surrounding stages; expected
// results are queued when a ray is issued and checked by a monitor.
module tb_ray_tracer_closest_hit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] ray_init;
  logic [27:0] ray_dir;
  logic [2:0]  obj_addr;
  logic [49:0] obj_data;
  logic [27:0] isect_init;
  logic [27:0] isect_dir;
  logic [49:0] isect_obj;
  logic [9:0]  isect_t;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] hit_color;
  logic [9:0]  hit_t;
  logic        hit_valid;
  logic [2:0]  hit_index;
`ifdef RT_ANY_HIT_EN
  logic        any_hit;
`endif

  always #5 clk = ~clk;

  ray_tracer_closest_hit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
`ifdef RT_ANY_HIT_EN
    .any_hit    (any_hit),
`endif
    .in_ready   (in_ready),
    .ray_init   (ray_init),
    .ray_dir    (ray_dir),
    .obj_addr   (obj_addr),
    .obj_data   (obj_data),
    .isect_init (isect_init),
    .isect_dir  (isect_dir),
    .isect_obj  (isect_obj),
    .isect_t    (isect_t),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .hit_color  (hit_color),
    .hit_t      (hit_t),
    .hit_valid  (hit_valid),
    .hit_index  (hit_index)
  );

  // Object table and intersection-stage model (t looked up by colour low bits).
  logic [49:0] rom   [8];
  logic [9:0]  t_tab [8];

  always @(posedge clk) obj_data <= rom[obj_addr];
  assign isect_t = t_tab[isect_obj[40:38]];

  typedef struct {
    logic [11:0] color;
    logic [9:0]  t;
    logic        valid;
    logic [2:0]  index;
    int          lat;
    int          start;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   busy  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int idx, input logic [9:0] t, input bit v, input int lat);
    exp_t e;
    e.color = v ? (12'hC50 + 12'(idx)) : 12'h000;
    e.t     = t;
    e.valid = v;
    e.index = 3'(idx);
    e.lat   = lat;
    e.start = 0;
    return e;
  endfunction

  task automatic set_t(input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2,
                       input logic [9:0] a3, input logic [9:0] a4, input logic [9:0] a5,
                       input logic [9:0] a6, input logic [9:0] a7);
    t_tab[0] = a0; t_tab[1] = a1; t_tab[2] = a2; t_tab[3] = a3;
    t_tab[4] = a4; t_tab[5] = a5; t_tab[6] = a6; t_tab[7] = a7;
  endtask

  // Issue one ray; returns on the falling edge after the handshake.
  task automatic send_ray(input logic [27:0] init, input logic [27:0] dir,
                          input bit want, input exp_t e);
    int guard;
    guard = 0;
    @(negedge clk);
    ray_init = init;
    ray_dir  = dir;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.start  = cyc;
    if (want) q.push_back(e);
    @(negedge clk);
    chk("isect_init", {36'd0, isect_init}, {36'd0, init});
    chk("isect_dir",  {36'd0, isect_dir},  {36'd0, dir});
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(q.size() == 0 && !busy && in_ready) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) chk("idle_timeout", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
  endtask

  // Monitor: compare each result once on arrival, then check it stays put.
  always @(negedge clk) begin
    if (!out_valid) begin
      busy = 1'b0;
    end else if (!busy) begin
      busy = 1'b1;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_out_valid: got out_valid=1 with no ray pending (cycle %0d)", cyc);
      end else begin
        cur = q.pop_front();
        chk("hit_color", {52'd0, hit_color}, {52'd0, cur.color});
        chk("hit_t",     {54'd0, hit_t},     {54'd0, cur.t});
        chk("hit_valid", {63'd0, hit_valid}, {63'd0, cur.valid});
        chk("hit_index", {61'd0, hit_index}, {61'd0, cur.index});
        chk("latency",   64'(cyc - cur.start), 64'(cur.lat));
      end
    end else begin
      chk("hold_t",     {54'd0, hit_t},     {54'd0, cur.t});
      chk("hold_color", {52'd0, hit_color}, {52'd0, cur.color});
      chk("hold_index", {61'd0, hit_index}, {61'd0, cur.index});
      chk("done_in_ready", {63'd0, in_ready}, 64'd0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ray_init  = 28'd0;
    ray_dir   = 28'd0;
`ifdef RT_ANY_HIT_EN
    any_hit   = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      rom[i] = {12'hC50 + 12'(i), 10'(3 * i + 1), 28'(1000 * i)};
    end
    set_t(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_hit_t",     {54'd0, hit_t},     64'h3FF);
    chk("rst_hit_color", {52'd0, hit_color}, 64'h000);
    chk("rst_hit_valid", {63'd0, hit_valid}, 64'd0);
    chk("rst_hit_index", {61'd0, hit_index}, 64'd0);
    chk("rst_obj_addr",  {61'd0, obj_addr},  64'd0);
    chk("rst_isect_obj", {14'd0, isect_obj}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single nearest hit
    set_t(10'h3FF, 10'h120, 10'h045, 10'h300, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
    send_ray(28'h1234567, 28'h0ABCDEF, 1'b1, mk(2, 10'h045, 1'b1, 10));
    wait_idle();

    // All miss
    set_t(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
    send_ray(28'h0000001, 28'hFFFFFFF, 1'b1, mk(0, 10'h3FF, 1'b0, 10));
    wait_idle();

    // Zero t rejected, tie keeps lower index
    set_t(10'h000, 10'h080, 10'h080, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
    send_ray(28'h5555555, 28'hAAAAAAA, 1'b1, mk(1, 10'h080, 1'b1, 10));
    wait_idle();

    // Backpressure; only the last object hits (t=1)
    set_t(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h001);
    out_ready = 1'b0;
    send_ray(28'h0F0F0F0, 28'h00000FF, 1'b1, mk(7, 10'h001, 1'b1, 10));
    begin
      int guard;
      guard = 0;
      while (!out_valid && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      in_valid = 1'b1;
      ray_init = 28'h7777777;
      @(negedge clk);
    end
    chk("bp_still_valid", {63'd0, out_valid}, 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready",  {63'd0, in_ready},  64'd1);
    chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    set_t(10'h200, 10'h100, 10'h150, 10'h100, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FE);
    send_ray(28'h0123456, 28'h6543210, 1'b1, mk(1, 10'h100, 1'b1, 10));
    wait_idle();

    // Reset in the 4th TEST cycle discards the ray
    set_t(10'h010, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
    send_ray(28'h3333333, 28'h4444444, 1'b0, mk(0, 10'h010, 1'b1, 10));
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_hit_t",     {54'd0, hit_t},     64'h3FF);
    chk("mid_rst_obj_addr",  {61'd0, obj_addr},  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_t(10'h3FE, 10'h3FD, 10'h3FC, 10'h3FB, 10'h3FA, 10'h3F9, 10'h3F8, 10'h3F7);
    send_ray(28'h0FEDCBA, 28'h0000010, 1'b1, mk(7, 10'h3F7, 1'b1, 10));
    wait_idle();

`ifdef RT_ANY_HIT_EN
    // Shadow ray stops after object 1; the same ray without any_hit scans all
    set_t(10'h3FF, 10'h200, 10'h010, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
    any_hit = 1'b1;
    send_ray(28'h1111111, 28'h2222222, 1'b1, mk(1, 10'h200, 1'b1, 4));
    any_hit = 1'b0;
    wait_idle();
    send_ray(28'h1111111, 28'h2222222, 1'b1, mk(2, 10'h010, 1'b1, 10));
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    if (q.size() != 0) chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
